// File: rtl/pia_kbd_port.sv
// pia_kbd_port: Apple-1 PIA keyboard pair (KBD/KBDCR) fed by a small character FIFO.
module pia_kbd_port #(
    parameter int DEPTH       = 8,
    parameter int PTR_W       = 3,
    parameter bit FORCE_UPPER = 1
) (
    input  logic             clk25,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [6:0]       key_data,
    output logic             key_ready,
    input  logic             cs,
    input  logic             enable,
    input  logic [1:0]       address,
    input  logic             w_en,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             overflow,
    output logic [PTR_W:0]   level
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [6:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic [6:0]       ctrl;
    logic [6:0]       folded;
    logic [3:0]       lvl4;
    logic             empty, full, push, pop, ctrl_wr;

    assign empty     = count == '0;
    assign full      = count == FULL_CNT;
    assign key_ready = ~full;
    assign level     = count;
    assign lvl4      = 4'(count);
    assign push      = key_valid & ~full;
    assign pop       = cs & enable & ~w_en & (address == 2'd0) & ~empty;
    assign ctrl_wr   = cs & enable & w_en & (address == 2'd1);
    assign folded    = (FORCE_UPPER && key_data >= 7'h61 && key_data <= 7'h7A) ? key_data - 7'h20 : key_data;

    always_comb begin
        dout = 8'h00;
        if (address == 2'd0)
            dout = empty ? 8'h00 : {1'b1, mem[rd_ptr]};
        else if (address == 2'd1)
            dout = {~empty, ctrl};
        else if (address == 2'd2)
            dout = {overflow, 3'b000, lvl4};
    end

    always_ff @(posedge clk25)
        if (push)
            mem[wr_ptr] <= folded;

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            ctrl     <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (ctrl_wr)
                ctrl <= din[6:0];
            // a dropped character outranks a same-edge software clear
            if (key_valid && full)
                overflow <= 1'b1;
            else if (ctrl_wr && din[7])
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pia_kbd_port.sv
// tb_pia_kbd_port: directed stimulus with a queue-based scoreboard checked by a negedge monitor.
module tb_pia_kbd_port;
    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [6:0] key_data = '0;
    logic       key_ready;
    logic       cs = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] address = '0;
    logic       w_en = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       overflow;
    logic [3:0] level;

    int vectors = 0;
    int miscompares = 0;

    string      nm_q[$];
    int         sel_q[$];
    logic [7:0] exp_q[$];
    logic [6:0] model[$];

    pia_kbd_port #(.DEPTH(8), .PTR_W(3), .FORCE_UPPER(1)) dut (
        .clk25(clk25), .rst_n(rst_n), .key_valid(key_valid), .key_data(key_data),
        .key_ready(key_ready), .cs(cs), .enable(enable), .address(address),
        .w_en(w_en), .din(din), .dout(dout), .overflow(overflow), .level(level)
    );

    always #20 clk25 = ~clk25;

    // sel: 0 dout at current address, 1 level, 2 key_ready, 3 overflow
    always @(negedge clk25) begin
        string      n;
        int         s;
        logic [7:0] e, a;
        while (exp_q.size() > 0) begin
            n = nm_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            a = s == 0 ? dout : s == 1 ? {4'b0, level} : s == 2 ? {7'b0, key_ready} : {7'b0, overflow};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got %02h expected %02h", n, a, e);
            end
        end
    end

    task automatic chk(input string n, input int s, input logic [1:0] a, input logic [7:0] e);
        cs = 1'b1; enable = 1'b0; w_en = 1'b0; address = a;
        nm_q.push_back(n); sel_q.push_back(s); exp_q.push_back(e);
        @(posedge clk25); #1;
    endtask

    task automatic push_key(input logic [6:0] d);
        key_valid = 1'b1; key_data = d;
        @(posedge clk25); #1;
        key_valid = 1'b0;
    endtask

    task automatic rd();
        cs = 1'b1; address = 2'd0; w_en = 1'b0; enable = 1'b1;
        @(posedge clk25); #1;
        enable = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; address = a; w_en = 1'b1; din = d; enable = 1'b1;
        @(posedge clk25); #1;
        enable = 1'b0; w_en = 1'b0;
    endtask

    task automatic push_pop(input logic [6:0] d);
        key_valid = 1'b1; key_data = d;
        cs = 1'b1; address = 2'd0; w_en = 1'b0; enable = 1'b1;
        @(posedge clk25); #1;
        key_valid = 1'b0; enable = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk25);
        #1 rst_n = 1'b1;
        chk("rst_level", 1, 0, 8'h00);
        chk("rst_ready", 2, 0, 8'h01);
        chk("rst_ovf", 3, 0, 8'h00);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_dout%0d", i), 0, 2'(i), 8'h00);

        push_key(7'h41);
        chk("single_kbdcr", 0, 1, 8'h80);
        chk("single_kbd", 0, 0, 8'hC1);
        rd();
        chk("single_level", 1, 0, 8'h00);
        chk("single_empty", 0, 0, 8'h00);
        rd();
        chk("empty_read_level", 1, 0, 8'h00);

        push_key(7'h61);
        chk("fold_lower_a", 0, 0, 8'hC1);
        rd();
        push_key(7'h7B);
        chk("no_fold_7b", 0, 0, 8'hFB);
        rd();

        for (int i = 0; i < 8; i++) push_key(7'(8'h30 + i));
        chk("full_ready", 2, 0, 8'h00);
        chk("full_level", 1, 0, 8'h08);
        push_key(7'h38);
        chk("ovf_set", 3, 0, 8'h01);
        chk("ovf_diag", 0, 2, 8'h88);
        wr(1, 8'h80);
        chk("ovf_clear", 3, 0, 8'h00);
        chk("ctrl_clear", 0, 1, 8'h80);
        key_valid = 1'b1; key_data = 7'h38;
        wr(1, 8'h80);
        key_valid = 1'b0;
        chk("ovf_set_wins", 3, 0, 8'h01);
        wr(1, 8'h80);
        chk("ovf_clear2", 3, 0, 8'h00);
        chk("drain_head0", 0, 0, 8'hB0);
        push_pop(7'h39);
        chk("full_pop_level", 1, 0, 8'h07);
        chk("full_pop_ovf", 3, 0, 8'h01);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("drain_head%0d", i), 0, 0, 8'(8'hB0 + i));
            rd();
        end
        chk("drain_level", 1, 0, 8'h00);
        wr(1, 8'h80);

        for (int i = 0; i < 3; i++) begin
            push_key(7'(8'h41 + i));
            model.push_back(7'(8'h41 + i));
        end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("wrap_head%0d", i), 0, 0, {1'b1, model[0]});
            push_pop(7'(8'h50 + i));
            void'(model.pop_front());
            model.push_back(7'(8'h50 + i));
        end
        chk("wrap_level", 1, 0, 8'h03);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap_tail%0d", i), 0, 0, {1'b1, model.pop_front()});
            rd();
        end
        chk("wrap_empty", 1, 0, 8'h00);

        push_key(7'h31);
        push_key(7'h32);
        cs = 1'b1; address = 2'd0; w_en = 1'b0;
        for (int i = 0; i < 25; i++) begin
            enable = (i == 10);
            @(posedge clk25); #1;
        end
        enable = 1'b0;
        chk("en_level", 1, 0, 8'h01);
        chk("en_head", 0, 0, 8'hB2);

        wr(1, 8'h15);
        wr(0, 8'h7F);
        wr(2, 8'h7F);
        wr(3, 8'h7F);
        cs = 1'b1; address = 2'd1; w_en = 1'b1; din = 8'h2A; enable = 1'b0;
        @(posedge clk25); #1;
        w_en = 1'b0;
        chk("ctrl_write", 0, 1, 8'h95);
        chk("diag_level", 0, 2, 8'h01);

        push_key(7'h33);
        rst_n = 1'b0;
        @(posedge clk25); #1;
        rst_n = 1'b1;
        chk("mid_rst_level", 1, 0, 8'h00);
        chk("mid_rst_ready", 2, 0, 8'h01);
        chk("mid_rst_kbd", 0, 0, 8'h00);
        chk("mid_rst_ctrl", 0, 1, 8'h00);

        repeat (2) @(posedge clk25);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
